// File: rtl/spi_arbiter_if.sv
// Requester and SPI-master handshake bundle shared by the arbiter and its environment.
interface spi_arbiter_if #(
    parameter int unsigned SIZE    = 40,
    parameter int unsigned CS_SIZE = 4
);
    localparam int unsigned CS_W = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1;

    // Requester side
    logic [CS_SIZE-1:0]      req_valid_in;
    logic [CS_SIZE*SIZE-1:0] req_data_in;
    logic [CS_SIZE-1:0]      req_ack_out;
    logic [CS_SIZE-1:0]      resp_valid_out;
    logic [SIZE-1:0]         resp_data_out;
    logic                    resp_err_out;
    logic                    busy_out;

    // SPI master side
    logic [SIZE-1:0]         spi_data_out;
    logic [CS_W-1:0]         spi_cs_select_out;
    logic                    spi_send_enable_out;
    logic                    spi_ready_in;
    logic [SIZE-1:0]         spi_data_in;

    // Arbiter view
    modport master (
        input  req_valid_in, req_data_in, spi_ready_in, spi_data_in,
        output req_ack_out, resp_valid_out, resp_data_out, resp_err_out, busy_out,
               spi_data_out, spi_cs_select_out, spi_send_enable_out
    );

    // Environment view (requesters plus SPI master)
    modport slave (
        output req_valid_in, req_data_in, spi_ready_in, spi_data_in,
        input  req_ack_out, resp_valid_out, resp_data_out, resp_err_out, busy_out,
               spi_data_out, spi_cs_select_out, spi_send_enable_out
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between CS_SIZE chip-select requesters,
// with an enforced inter-frame gap and a watchdog on the SPI ready handshake.
module spi_arbiter #(
    parameter int unsigned SIZE       = 40,
    parameter int unsigned CS_SIZE    = 4,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic          clk_in,
    input  logic          reset_in,
    spi_arbiter_if.master bus
);
    localparam int unsigned CS_W  = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1;
    localparam int unsigned SUM_W = CS_W + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t              state_q;
    logic [GAP_W-1:0]    gap_q;
    logic [WD_W-1:0]     wd_q;
    logic [CS_W-1:0]     last_q;
    logic [CS_W-1:0]     cs_q;
    logic [SIZE-1:0]     spi_data_q;
    logic                en_q;
    logic [CS_SIZE-1:0]  ack_q;
    logic [CS_SIZE-1:0]  resp_valid_q;
    logic [SIZE-1:0]     resp_data_q;
    logic                resp_err_q;
    logic                busy_q;

    logic                pick_found_c;
    logic [CS_W-1:0]     pick_idx_c;
    logic [SUM_W-1:0]    cand_c;
    logic [SIZE-1:0]     pick_data_c;
    logic                wd_hit_c;

    // Circular search for the first pending request after the last grant
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        cand_c       = '0;
        for (int unsigned k = 1; k <= CS_SIZE; k++) begin
            cand_c = {1'b0, last_q} + SUM_W'(k);
            if (cand_c >= SUM_W'(CS_SIZE)) begin
                cand_c = cand_c - SUM_W'(CS_SIZE);
            end
            if (!pick_found_c && bus.req_valid_in[cand_c[CS_W-1:0]]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = cand_c[CS_W-1:0];
            end
        end
    end

    // Select the datagram slice of the chosen requester
    always_comb begin
        pick_data_c = '0;
        for (int unsigned i = 0; i < CS_SIZE; i++) begin
            if (pick_idx_c == CS_W'(i)) begin
                pick_data_c = bus.req_data_in[i*SIZE +: SIZE];
            end
        end
    end

    assign wd_hit_c = (wd_q == WD_W'(TIMEOUT - 1));

    // Scheduler FSM; every output is a register updated here
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= GAP;
            gap_q        <= GAP_W'(GAP_CYCLES);
            wd_q         <= '0;
            last_q       <= CS_W'(CS_SIZE - 1);
            cs_q         <= '0;
            spi_data_q   <= '0;
            en_q         <= 1'b0;
            ack_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            ack_q        <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found_c) begin
                        ack_q      <= CS_SIZE'(1) << pick_idx_c;
                        spi_data_q <= pick_data_c;
                        cs_q       <= pick_idx_c;
                        en_q       <= 1'b1;
                        wd_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START, BUSY: begin
                    // A completing frame beats a coincident watchdog expiry
                    if (state_q == BUSY && bus.spi_ready_in) begin
                        state_q <= DONE;
                    end else if (wd_hit_c) begin
                        resp_valid_q <= CS_SIZE'(1) << cs_q;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                        en_q         <= 1'b0;
                        last_q       <= cs_q;
                        gap_q        <= GAP_W'(GAP_CYCLES);
                        state_q      <= GAP;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                        if (state_q == START && !bus.spi_ready_in) begin
                            state_q <= BUSY;
                        end
                    end
                end
                DONE: begin
                    resp_valid_q <= CS_SIZE'(1) << cs_q;
                    resp_data_q  <= bus.spi_data_in;
                    en_q         <= 1'b0;
                    last_q       <= cs_q;
                    gap_q        <= GAP_W'(GAP_CYCLES);
                    state_q      <= GAP;
                end
                GAP: begin
                    if (gap_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    gap_q   <= GAP_W'(GAP_CYCLES);
                    state_q <= GAP;
                end
            endcase
        end
    end

    assign bus.req_ack_out         = ack_q;
    assign bus.resp_valid_out      = resp_valid_q;
    assign bus.resp_data_out       = resp_data_q;
    assign bus.resp_err_out        = resp_err_q;
    assign bus.busy_out            = busy_q;
    assign bus.spi_data_out        = spi_data_q;
    assign bus.spi_cs_select_out   = cs_q;
    assign bus.spi_send_enable_out = en_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a behavioural SPI master model.
module tb_spi_arbiter;
    localparam int unsigned SIZE       = 40;
    localparam int unsigned CS_SIZE    = 4;
    localparam int unsigned GAP_CYCLES = 16;
    localparam int unsigned TIMEOUT    = 64;
    localparam int          FRAME      = 5;
    localparam logic [39:0] KEY        = 40'hAB_5555_AAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset_in  = 1'b1;
    logic [CS_SIZE-1:0]      req_valid = '0;
    logic [CS_SIZE*SIZE-1:0] req_data  = '0;
    logic                    hang      = 1'b0;

    spi_arbiter_if #(.SIZE(SIZE), .CS_SIZE(CS_SIZE)) bus ();

    spi_arbiter #(
        .SIZE(SIZE), .CS_SIZE(CS_SIZE), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in   (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    assign bus.req_valid_in = req_valid;
    assign bus.req_data_in  = req_data;

    // Free-running cycle count and registered view of reset
    int   cyc      = 0;
    logic rst_prev = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset_in;
    end

    // SPI master model: ready drops when a frame starts, rises FRAME+1 cycles later
    logic        m_ready = 1'b1;
    logic [39:0] m_rx    = '0;
    logic [39:0] m_tx    = '0;
    logic        m_busy  = 1'b0;
    logic        m_armed = 1'b0;
    int          m_cnt   = 0;
    int          rise_cyc = 0;
    assign bus.spi_ready_in = m_ready;
    assign bus.spi_data_in  = m_rx;

    always @(posedge clk) begin
        if (!bus.spi_send_enable_out) m_armed <= 1'b1;
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_ready  <= 1'b1;
                m_busy   <= 1'b0;
                m_rx     <= m_tx ^ KEY;
                rise_cyc <= cyc + 1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (!hang && m_armed && bus.spi_send_enable_out && m_ready) begin
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_cnt   <= FRAME;
            m_tx    <= bus.spi_data_out;
            m_armed <= 1'b0;
            m_rx    <= '0;
        end
    end

    typedef struct packed {
        logic [3:0]  oh;
        logic [1:0]  idx;
        logic [39:0] data;
    } ack_t;

    typedef struct packed {
        logic [3:0]  oh;
        logic [39:0] data;
        logic        err;
    } resp_t;

    ack_t  exp_ack[$];
    resp_t exp_resp[$];

    int checks   = 0;
    int errors   = 0;
    int chk_req  = 0;
    int chk_done = 0;

    // Monitor: sole owner of the counters, compares everything the DUT presents
    initial begin : monitor
        ack_t        ea;
        resp_t       er;
        int          ack_cyc;
        int          low_cnt;
        logic [39:0] lat_data;
        logic [1:0]  lat_cs;
        logic        seen_rst;
        ack_cyc  = 0;
        low_cnt  = 0;
        lat_data = '0;
        lat_cs   = '0;
        seen_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                seen_rst = 1'b1;
                checks++;
                if ({bus.req_ack_out, bus.resp_valid_out, bus.resp_data_out, bus.resp_err_out,
                     bus.busy_out, bus.spi_send_enable_out, bus.spi_data_out, bus.spi_cs_select_out}
                    !== {4'b0, 4'b0, 40'b0, 1'b0, 1'b1, 1'b0, 40'b0, 2'b0}) begin
                    errors++;
                    $display("FAIL reset_state @%0d: ack=%b rv=%b rd=%h err=%b busy=%b en=%b sd=%h cs=%0d, expected all 0 with busy=1",
                             cyc, bus.req_ack_out, bus.resp_valid_out, bus.resp_data_out, bus.resp_err_out,
                             bus.busy_out, bus.spi_send_enable_out, bus.spi_data_out, bus.spi_cs_select_out);
                end
            end
            if (seen_rst) begin
                if (bus.req_ack_out != '0) begin
                    checks++;
                    if (exp_ack.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack @%0d: got %b, expected none", cyc, bus.req_ack_out);
                    end else begin
                        ea = exp_ack.pop_front();
                        if ({bus.req_ack_out, bus.spi_cs_select_out, bus.spi_data_out, bus.spi_send_enable_out}
                            !== {ea.oh, ea.idx, ea.data, 1'b1}) begin
                            errors++;
                            $display("FAIL grant @%0d: got ack=%b cs=%0d data=%h en=%b, expected ack=%b cs=%0d data=%h en=1",
                                     cyc, bus.req_ack_out, bus.spi_cs_select_out, bus.spi_data_out,
                                     bus.spi_send_enable_out, ea.oh, ea.idx, ea.data);
                        end
                    end
                    checks++;
                    if (low_cnt < GAP_CYCLES) begin
                        errors++;
                        $display("FAIL gap_len @%0d: enable low %0d cycles, expected >= %0d", cyc, low_cnt, GAP_CYCLES);
                    end
                    ack_cyc  = cyc;
                    lat_data = bus.spi_data_out;
                    lat_cs   = bus.spi_cs_select_out;
                end else if (bus.spi_send_enable_out) begin
                    checks++;
                    if ({bus.spi_data_out, bus.spi_cs_select_out} !== {lat_data, lat_cs}) begin
                        errors++;
                        $display("FAIL spi_stable @%0d: got data=%h cs=%0d, expected data=%h cs=%0d",
                                 cyc, bus.spi_data_out, bus.spi_cs_select_out, lat_data, lat_cs);
                    end
                end
                low_cnt = bus.spi_send_enable_out ? 0 : low_cnt + 1;

                if (bus.resp_valid_out != '0) begin
                    checks++;
                    if (exp_resp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp @%0d: got rv=%b data=%h err=%b, expected none",
                                 cyc, bus.resp_valid_out, bus.resp_data_out, bus.resp_err_out);
                    end else begin
                        er = exp_resp.pop_front();
                        if ({bus.resp_valid_out, bus.resp_data_out, bus.resp_err_out} !== {er.oh, er.data, er.err}) begin
                            errors++;
                            $display("FAIL resp @%0d: got rv=%b data=%h err=%b, expected rv=%b data=%h err=%b",
                                     cyc, bus.resp_valid_out, bus.resp_data_out, bus.resp_err_out, er.oh, er.data, er.err);
                        end
                        checks++;
                        if (er.err) begin
                            if (cyc - ack_cyc != int'(TIMEOUT)) begin
                                errors++;
                                $display("FAIL abort_latency: got %0d cycles after enable, expected %0d", cyc - ack_cyc, TIMEOUT);
                            end
                        end else if (cyc != rise_cyc + 2) begin
                            errors++;
                            $display("FAIL resp_latency: resp at %0d, expected %0d (ready high at %0d)", cyc, rise_cyc + 2, rise_cyc);
                        end
                    end
                end
            end
            if (chk_req != chk_done) begin
                checks += 2;
                if (exp_ack.size() != 0) begin
                    errors++;
                    $display("FAIL pending_acks: %0d outstanding, expected 0", exp_ack.size());
                end
                if (exp_resp.size() != 0) begin
                    errors++;
                    $display("FAIL pending_resps: %0d outstanding, expected 0", exp_resp.size());
                end
                chk_done = chk_req;
            end
        end
    end

    function automatic logic [39:0] mk_data(input int i, input int k);
        return {8'(8'h30 + i*16 + k), 32'hC0DE_0000 + 32'(i*256 + k)};
    endfunction

    task automatic expect_frame(input int i, input logic [39:0] d, input logic [39:0] rd, input logic err);
        exp_ack.push_back('{oh: 4'b0001 << i, idx: 2'(i), data: d});
        exp_resp.push_back('{oh: 4'b0001 << i, data: rd, err: err});
    endtask

    int seq [4] = '{0, 0, 0, 0};

    // Requesters: hold valid until acked, re-request with fresh data while frames remain
    task automatic drive(input int n0, input int n1, input int n2, input int n3, input logic [3:0] late);
        int left [4];
        int budget;
        left = '{n0, n1, n2, n3};
        for (int i = 0; i < 4; i++) begin
            req_data[i*SIZE +: SIZE] = mk_data(i, seq[i]);
            req_valid[i] = (left[i] > 0) && !late[i];
        end
        budget = 4000;
        while ((left[0] + left[1] + left[2] + left[3]) > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            for (int i = 0; i < 4; i++) begin
                if (bus.req_ack_out[i] && left[i] > 0) begin
                    left[i]--;
                    seq[i]++;
                    if (left[i] > 0) req_data[i*SIZE +: SIZE] = mk_data(i, seq[i]);
                    else             req_valid[i] = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        if (late[j] && left[j] > 0) req_valid[j] = 1'b1;
                    end
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = budget;
        while ((exp_ack.size() != 0 || exp_resp.size() != 0) && b > 0) begin
            @(negedge clk);
            b--;
        end
        repeat (2) @(negedge clk);
        chk_req++;
        repeat (2) @(negedge clk);
    endtask

    // Stimulus
    initial begin : stimulus
        int b;
        repeat (4) @(negedge clk);
        reset_in = 1'b0;

        // Single request after reset: requester 0 has priority
        expect_frame(0, 40'h01_0000_0000, 40'hAA_5555_AAAA, 1'b0);
        req_data[0 +: SIZE] = 40'h01_0000_0000;
        req_valid = 4'b0001;
        b = 500;
        while (!bus.req_ack_out[0] && b > 0) begin
            @(negedge clk);
            b--;
        end
        req_valid = '0;
        wait_done(500);

        // All four held for two frames each; last grant was 0 so rotation starts at 1
        expect_frame(1, mk_data(1, 0), mk_data(1, 0) ^ KEY, 1'b0);
        expect_frame(2, mk_data(2, 0), mk_data(2, 0) ^ KEY, 1'b0);
        expect_frame(3, mk_data(3, 0), mk_data(3, 0) ^ KEY, 1'b0);
        expect_frame(0, mk_data(0, 0), mk_data(0, 0) ^ KEY, 1'b0);
        expect_frame(1, mk_data(1, 1), mk_data(1, 1) ^ KEY, 1'b0);
        expect_frame(2, mk_data(2, 1), mk_data(2, 1) ^ KEY, 1'b0);
        expect_frame(3, mk_data(3, 1), mk_data(3, 1) ^ KEY, 1'b0);
        expect_frame(0, mk_data(0, 1), mk_data(0, 1) ^ KEY, 1'b0);
        drive(2, 2, 2, 2, 4'b0000);
        wait_done(2000);

        // Requester 2 held, requester 1 joins after grant 2: 3 and 0 idle so 1 wins next
        expect_frame(2, mk_data(2, 2), mk_data(2, 2) ^ KEY, 1'b0);
        expect_frame(1, mk_data(1, 2), mk_data(1, 2) ^ KEY, 1'b0);
        expect_frame(2, mk_data(2, 3), mk_data(2, 3) ^ KEY, 1'b0);
        drive(0, 1, 2, 0, 4'b0010);
        wait_done(1000);

        // SPI never starts: watchdog abort, then a normal frame
        hang = 1'b1;
        expect_frame(3, mk_data(3, 2), 40'h0, 1'b1);
        drive(0, 0, 0, 1, 4'b0000);
        wait_done(1000);
        hang = 1'b0;
        expect_frame(0, mk_data(0, 2), mk_data(0, 2) ^ KEY, 1'b0);
        drive(1, 0, 0, 0, 4'b0000);
        wait_done(1000);

        // Reset during BUSY: grant seen, no response, priority restarts at 0
        exp_ack.push_back('{oh: 4'b0010, idx: 2'd1, data: mk_data(1, 3)});
        drive(0, 1, 0, 0, 4'b0000);
        b = 20;
        while (bus.spi_ready_in && b > 0) begin
            @(negedge clk);
            b--;
        end
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        expect_frame(1, mk_data(1, 4), mk_data(1, 4) ^ KEY, 1'b0);
        expect_frame(2, mk_data(2, 4), mk_data(2, 4) ^ KEY, 1'b0);
        drive(0, 1, 1, 0, 4'b0000);
        wait_done(1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound
    initial begin : guard
        #300000;
        $display("FAIL global_timeout: simulation did not complete, expected completion before 300000");
        $fatal(1, "simulation time bound exceeded");
    end
endmodule
